// File: rtl/thermo_bar_decoder_pkg.sv
// Shared code/level helpers and FSM state type for the thermometer bar decoder.
// Codes follow the 8-bit priority encoder's leading-ones format.
package thermo_bar_decoder_pkg;

  localparam logic [3:0] CODE_EMPTY = 4'b1111;
  localparam logic [3:0] CODE_FULL  = 4'b0000;
  localparam logic [3:0] LEVEL_MAX  = 4'd8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_e;

  // 4'b0001..4'b0111 have no encoder meaning.
  function automatic logic code_is_illegal(input logic [3:0] code);
    return (code != CODE_FULL) && !code[3];
  endfunction

  function automatic logic [3:0] code_to_level(input logic [3:0] code);
    return (code == CODE_FULL) ? LEVEL_MAX : 4'd15 - code;
  endfunction

  function automatic logic [3:0] level_to_code(input logic [3:0] level);
    return (level == LEVEL_MAX) ? CODE_FULL : 4'd15 - level;
  endfunction

endpackage

// File: rtl/thermo_bar_if.sv
// Request/bar bundle between a code source (master) and the bar decoder (slave).
interface thermo_bar_if;
  logic [3:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] bar;
  logic [3:0] level_code;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output code_in, code_valid,
    input  code_ready, bar, level_code, busy, done, err
  );

  modport slave (
    input  code_in, code_valid,
    output code_ready, bar, level_code, busy, done, err
  );
endinterface

// File: rtl/thermo_bar_decoder_level_to_bar.sv
// Combinational level (0..8) to left-justified 8-bit thermometer bar.
module thermo_level_to_bar (
  input  logic [3:0] level,
  output logic [7:0] bar
);
  always_comb begin
    bar = '0;
    for (int i = 0; i < 8; i++) begin
      bar[i] = (int'(level) + i >= 8);
    end
  end
endmodule

// File: rtl/thermo_bar_decoder.sv
// Slew-limited thermometer bar driver: ramps one segment per STEP_CYCLES
// toward the level named by an encoder-format code.
module thermo_bar_decoder
  import thermo_bar_decoder_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic      clk,
  input  logic      reset,
  thermo_bar_if.slave bus
);

  localparam int                DIV_W      = $clog2(STEP_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(STEP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       target_q, target_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       bar_q, bar_d;
  logic [3:0]       code_q, code_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic [3:0]       req_level;

  assign bus.code_ready = (state_q == ST_IDLE) && !reset;
  assign accept         = bus.code_valid && bus.code_ready;
  assign req_level      = code_to_level(bus.code_in);

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    div_d    = div_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (code_is_illegal(bus.code_in)) begin
            err_d = 1'b1;
          end else if (req_level == level_q) begin
            done_d = 1'b1;
          end else begin
            target_d = req_level;
            div_d    = DIV_RELOAD;
            state_d  = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          level_d = (target_q > level_q) ? level_q + 4'd1 : level_q - 4'd1;
          div_d   = DIV_RELOAD;
          // Exit on the same edge the final segment lands.
          if (level_d == target_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bar and code are derived from the next level so all three update together.
  thermo_level_to_bar u_level_to_bar (
    .level (level_d),
    .bar   (bar_d)
  );
  assign code_d = level_to_code(level_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      target_q <= '0;
      div_q    <= '0;
      bar_q    <= '0;
      code_q   <= CODE_EMPTY;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      div_q    <= div_d;
      bar_q    <= bar_d;
      code_q   <= code_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.bar        = bar_q;
  assign bus.level_code = code_q;
  assign bus.busy       = (state_q == ST_RAMP);
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: doc/thermo_bar_decoder.md
# thermo_bar_decoder

Decodes the 4-bit leading-ones code produced by the team's 8-bit priority encoder back into an 8-bit left-justified thermometer bar. Code 4'b1111 means zero leading ones, 4'b1110 through 4'b1000 mean one through seven, and 4'b0000 means eight. The bar does not jump to its new value: it ramps one segment at a time at a programmable rate. This makes the block usable as a slew-limited bar-graph driver. The output code tracks the current bar, so feeding `bar` back through the encoder reproduces `level_code`.

## Interface
Parameters:
- STEP_CYCLES, default 4: clock cycles per one-segment step. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- code_in  input  4  requested code in encoder format.
- code_valid  input  1  `code_in` is valid this cycle.
- code_ready  output  1  block can accept a code; high exactly when the FSM is IDLE and `reset` is low.
- bar  output  8  registered thermometer: the top `level` bits (MSB first) are 1, the rest are 0.
- level_code  output  4  registered encoder-format code of the current `bar`.
- busy  output  1  high while the FSM is in RAMP.
- done  output  1  one-cycle pulse when the bar reaches the target of a valid request.
- err  output  1  one-cycle pulse when an illegal code is accepted.

## Operation
Level and code mapping:
- Internal level L is 0..8 and is held in 4 bits.
- Code to level: 4'b0000 gives 8; 4'b1000..4'b1111 give 15 minus the code; 4'b0001..4'b0111 are illegal.
- Level to code: 8 gives 4'b0000; otherwise the code is 15 minus L.
- `bar` bit i (7 down to 0) is 1 when i is at least 8 minus L.

FSM states are IDLE and RAMP.
- **Accept:** a handshake is `code_valid` high and `code_ready` high at a clock edge.
- **IDLE, legal code, target T equal to L:** stay in IDLE; pulse `done` on the next cycle.
- **IDLE, legal code, T different from L:** latch T; load the divider with STEP_CYCLES minus 1; go to RAMP.
- **IDLE, illegal code:** the code is consumed. Pulse `err` on the next cycle. L, the target and the state are unchanged, and there is no `done`.
- **RAMP, each edge:**
  - If the divider is not 0, decrement it.
  - Otherwise step L by one toward T and reload the divider.
  - If the new L equals T, go to IDLE and pulse `done` on the following cycle.
- Requests are never queued. `code_valid` while busy is ignored, and the source must hold it until accepted.
- `bar`, `level_code` and L are always mutually consistent, including at every intermediate step.

## Timing
- **Reset values:** `bar` 8'h00, `level_code` 4'hF, L 0, `busy` 0, `done` 0, `err` 0, state IDLE, divider 0. `code_ready` is 0 while `reset` is high and 1 in the first cycle after.
- **Reset mid-ramp:** on the reset edge the bar returns to 8'h00, the target is discarded and no `done` is generated.
- **Ramp latency:** let the accept edge be E0 and the distance be d = |T − L|.
  - Step k lands on edge E0 + k·STEP_CYCLES.
  - The last step is at E0 + d·STEP_CYCLES. On that same edge `busy` falls and `code_ready` rises.
  - `done` is high for the one cycle after that edge.
- **Zero-distance and illegal requests:** `done` or `err` is high in the cycle after E0. `code_ready` stays high throughout, so back-to-back accepts are legal.
- **Boundaries:** L never leaves 0..8; a ramp 0→8 takes 8·STEP_CYCLES cycles. With STEP_CYCLES=1 the block steps on every edge.

## Structure
- **Shared package:** the level-to-code and code-to-level functions, the illegal-code test, the code constants CODE_EMPTY=4'b1111 and CODE_FULL=4'b0000, and the FSM state enum.
- **Sub-module `thermo_level_to_bar`:** combinational L → 8-bit bar. Its output is registered in the top level.
- **Top level:** FSM, divider counter sized with $clog2(STEP_CYCLES+1), level register and output registers.

## Test plan
- **Reset:** hold `reset` 2 cycles → `bar`=8'h00, `level_code`=4'hF, `busy`/`done`/`err`=0, `code_ready`=0 during reset and 1 after.
- **Full up-ramp:** STEP_CYCLES=4; accept 4'b0000 from L=0 → `bar` goes 8'h80, C0, …, FF on edges E0+4, +8, …, +32. `done` pulses once after E0+32, and `level_code` ends at 4'h0.
- **Down-ramp:** from 8'hFF accept 4'b1101 → `bar` goes FE, FC, F8, F0, E0, C0 (6 steps). `done` pulses, `level_code`=4'hD, and `bar` re-encodes to 4'b1101.
- **Illegal and zero-distance:** at L=3 accept 4'b0101 → `err` pulses one cycle, `bar` stays 8'hE0, no `done`. Then accept 4'b1100 → `done` pulses next cycle, `busy` never rises.
- **Busy ignore:** while ramping toward 4'b1000, hold `code_valid` with 4'b1111 → not accepted until `code_ready` returns. It is then accepted, and the bar ramps back down to 8'h00.
- **Reset mid-ramp:** assert `reset` at step 3 of a 0→8 ramp → next cycle `bar`=8'h00, no `done`, and a fresh request is accepted normally.
